// File: rtl/input_port_arbiter_if.sv
// Bundles the requester side and the SOC input-port side of the arbiter.
// The arbiter uses the slave modport. Producers and the SOC model use master.
interface input_port_arbiter_if #(
  parameter int NUM_SOURCES = 2,
  parameter int DATA_WIDTH  = 8
);
  localparam int ID_WIDTH = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;

  logic [NUM_SOURCES-1:0]            req_valid_in;
  logic [NUM_SOURCES*DATA_WIDTH-1:0] req_data_in;
  logic [NUM_SOURCES-1:0]            req_ready_out;
  logic                              fgi_in;
  logic [DATA_WIDTH-1:0]             data_out;
  logic                              load_out;
  logic [ID_WIDTH-1:0]               grant_id_out;
  logic                              busy_out;
  logic                              timeout_out;

  modport master (
    output req_valid_in, req_data_in, fgi_in,
    input  req_ready_out, data_out, load_out, grant_id_out, busy_out, timeout_out
  );

  modport slave (
    input  req_valid_in, req_data_in, fgi_in,
    output req_ready_out, data_out, load_out, grant_id_out, busy_out, timeout_out
  );
endinterface

// File: rtl/input_port_arbiter.sv
// Round-robin arbiter sharing the SOC's single input port between several
// character producers. Each grant issues exactly one load pulse, then waits
// for the SOC input flag (FGI) to rise and fall before the next grant.
// If FGI never rises, the wait gives up after SET_TIMEOUT cycles and the
// timeout pulse shows in the first IDLE cycle after the last waiting cycle.
module input_port_arbiter #(
  parameter int NUM_SOURCES = 2,
  parameter int DATA_WIDTH  = 8,
  parameter int SET_TIMEOUT = 15
) (
  input logic                clock,
  input logic                reset_n_in,
  input_port_arbiter_if.slave bus
);
  localparam int ID_WIDTH  = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;
  localparam int CNT_WIDTH = $clog2(SET_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_SET, WAIT_CLR} state_t;

  state_t                 state;
  logic [ID_WIDTH-1:0]    ptr;
  logic [CNT_WIDTH-1:0]   set_count;

  logic                   grant_found;
  logic [ID_WIDTH-1:0]    grant_idx;
  logic [ID_WIDTH-1:0]    next_ptr;
  logic [NUM_SOURCES-1:0] grant_onehot;
  logic [DATA_WIDTH-1:0]  grant_data;

  // Pick the first valid source scanning from ptr upward with wrap-around.
  always_comb begin
    int cand;
    cand         = 0;
    grant_found  = 1'b0;
    grant_idx    = '0;
    grant_onehot = '0;
    grant_data   = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      cand = int'(ptr) + i;
      if (cand >= NUM_SOURCES) cand = cand - NUM_SOURCES;
      if (!grant_found && bus.req_valid_in[cand[ID_WIDTH-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[ID_WIDTH-1:0];
      end
    end
    for (int j = 0; j < NUM_SOURCES; j++) begin
      if (grant_found && grant_idx == ID_WIDTH'(j)) begin
        grant_onehot[j] = 1'b1;
        grant_data      = bus.req_data_in[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    if (int'(grant_idx) == NUM_SOURCES - 1) next_ptr = '0;
    else                                    next_ptr = grant_idx + 1'b1;
  end

  // Grant sequencer: one load per character, then track FGI set and clear.
  always_ff @(posedge clock or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state             <= IDLE;
      ptr               <= '0;
      set_count         <= '0;
      bus.data_out      <= '0;
      bus.load_out      <= 1'b0;
      bus.req_ready_out <= '0;
      bus.grant_id_out  <= '0;
      bus.busy_out      <= 1'b0;
      bus.timeout_out   <= 1'b0;
    end else begin
      bus.load_out      <= 1'b0;
      bus.req_ready_out <= '0;
      bus.timeout_out   <= 1'b0;
      case (state)
        IDLE: begin
          if (!bus.fgi_in && grant_found) begin
            bus.data_out      <= grant_data;
            bus.grant_id_out  <= grant_idx;
            bus.req_ready_out <= grant_onehot;
            bus.load_out      <= 1'b1;
            bus.busy_out      <= 1'b1;
            ptr               <= next_ptr;
            state             <= LOAD;
          end
        end
        LOAD: begin
          set_count <= '0;
          state     <= WAIT_SET;
        end
        WAIT_SET: begin
          if (bus.fgi_in) begin
            state <= WAIT_CLR;
          end else if (set_count == CNT_WIDTH'(SET_TIMEOUT - 1)) begin
            bus.timeout_out <= 1'b1;
            bus.busy_out    <= 1'b0;
            state           <= IDLE;
          end else begin
            set_count <= set_count + 1'b1;
          end
        end
        WAIT_CLR: begin
          if (!bus.fgi_in) begin
            bus.busy_out <= 1'b0;
            state        <= IDLE;
          end
        end
        default: begin
          bus.busy_out <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_input_port_arbiter.sv
// Directed bench for input_port_arbiter with two sources and SET_TIMEOUT=15.
// A vector table covers round-robin alternation and a single-source load.
// Hand-written sequences cover the FGI hold, timeout, async reset and withdrawal cases.
module tb_input_port_arbiter;
  localparam int NUM_SOURCES = 2;
  localparam int DATA_WIDTH  = 8;
  localparam int SET_TIMEOUT = 15;

  typedef struct {
    logic       load;
    logic [1:0] ready;
    logic [7:0] data;
    logic       gid;
    logic       busy;
    logic       tmo;
  } out_t;

  typedef struct {
    logic [1:0] valid;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       fgi;
    out_t       exp;
  } vec_t;

  logic clock = 1'b0;
  logic reset_n_in;
  int   checks = 0;
  int   errors = 0;
  vec_t vectors[$];

  input_port_arbiter_if #(.NUM_SOURCES(NUM_SOURCES), .DATA_WIDTH(DATA_WIDTH)) bus ();

  input_port_arbiter #(
    .NUM_SOURCES(NUM_SOURCES),
    .DATA_WIDTH (DATA_WIDTH),
    .SET_TIMEOUT(SET_TIMEOUT)
  ) dut (
    .clock     (clock),
    .reset_n_in(reset_n_in),
    .bus       (bus.slave)
  );

  // Free-running 10-time-unit clock.
  always #5 clock = ~clock;

  function automatic out_t mko(input logic ld, input logic [1:0] rdy, input logic [7:0] dat,
                               input logic gid, input logic busy, input logic tmo);
    out_t o;
    o.load  = ld;
    o.ready = rdy;
    o.data  = dat;
    o.gid   = gid;
    o.busy  = busy;
    o.tmo   = tmo;
    return o;
  endfunction

  function automatic vec_t mkv(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1,
                               input logic fgi, input out_t e);
    vec_t r;
    r.valid = v;
    r.d0    = d0;
    r.d1    = d1;
    r.fgi   = fgi;
    r.exp   = e;
    return r;
  endfunction

  task automatic applyStimulus(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1,
                               input logic fgi);
    @(negedge clock);
    bus.req_valid_in = v;
    bus.req_data_in  = {d1, d0};
    bus.fgi_in       = fgi;
  endtask

  task automatic checkOutput(input string name, input out_t e);
    checks++;
    if (bus.load_out !== e.load || bus.req_ready_out !== e.ready || bus.data_out !== e.data ||
        bus.grant_id_out !== e.gid || bus.busy_out !== e.busy || bus.timeout_out !== e.tmo) begin
      errors++;
      $display("[TB] FAIL %s: got load=%b ready=%b data=%h gid=%b busy=%b tmo=%b, expected load=%b ready=%b data=%h gid=%b busy=%b tmo=%b",
               name, bus.load_out, bus.req_ready_out, bus.data_out, bus.grant_id_out,
               bus.busy_out, bus.timeout_out, e.load, e.ready, e.data, e.gid, e.busy, e.tmo);
    end
  endtask

  task automatic stepCheck(input string name, input logic [1:0] v, input logic [7:0] d0,
                           input logic [7:0] d1, input logic fgi, input out_t e);
    applyStimulus(v, d0, d1, fgi);
    @(posedge clock);
    #1;
    checkOutput(name, e);
  endtask

  // LOAD -> WAIT_SET, FGI rises -> WAIT_CLR, FGI falls -> IDLE.
  task automatic finishHandshake(input string name, input logic [7:0] dat, input logic gid);
    stepCheck({name, "_wset"}, 2'b00, 8'h00, 8'h00, 1'b0, mko(1'b0, 2'b00, dat, gid, 1'b1, 1'b0));
    stepCheck({name, "_wclr"}, 2'b00, 8'h00, 8'h00, 1'b1, mko(1'b0, 2'b00, dat, gid, 1'b1, 1'b0));
    stepCheck({name, "_idle"}, 2'b00, 8'h00, 8'h00, 1'b0, mko(1'b0, 2'b00, dat, gid, 1'b0, 1'b0));
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got time limit reached, expected summary before limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main directed sequence.
  initial begin
    logic       g;
    logic [7:0] d;
    logic [1:0] r;

    // Both sources always valid: grants alternate 0,1,0,1 with a fast SOC.
    for (int k = 0; k < 4; k++) begin
      g = k[0];
      d = g ? 8'h42 : 8'h41;
      r = g ? 2'b10 : 2'b01;
      vectors.push_back(mkv(2'b11, 8'h41, 8'h42, 1'b0, mko(1'b1, r,     d, g, 1'b1, 1'b0)));
      vectors.push_back(mkv(2'b11, 8'h41, 8'h42, 1'b0, mko(1'b0, 2'b00, d, g, 1'b1, 1'b0)));
      vectors.push_back(mkv(2'b11, 8'h41, 8'h42, 1'b1, mko(1'b0, 2'b00, d, g, 1'b1, 1'b0)));
      vectors.push_back(mkv(2'b11, 8'h41, 8'h42, 1'b0, mko(1'b0, 2'b00, d, g, 1'b0, 1'b0)));
    end
    // Single source 0: FGI rises a cycle after the load and stays up five cycles.
    vectors.push_back(mkv(2'b01, 8'h41, 8'h00, 1'b0, mko(1'b1, 2'b01, 8'h41, 1'b0, 1'b1, 1'b0)));
    vectors.push_back(mkv(2'b00, 8'h41, 8'h00, 1'b0, mko(1'b0, 2'b00, 8'h41, 1'b0, 1'b1, 1'b0)));
    for (int k = 0; k < 5; k++)
      vectors.push_back(mkv(2'b00, 8'h41, 8'h00, 1'b1, mko(1'b0, 2'b00, 8'h41, 1'b0, 1'b1, 1'b0)));
    vectors.push_back(mkv(2'b00, 8'h41, 8'h00, 1'b0, mko(1'b0, 2'b00, 8'h41, 1'b0, 1'b0, 1'b0)));

    reset_n_in       = 1'b0;
    bus.req_valid_in = '0;
    bus.req_data_in  = '0;
    bus.fgi_in       = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset", mko(1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0));
    @(negedge clock);
    reset_n_in = 1'b1;

    for (int i = 0; i < vectors.size(); i++)
      stepCheck($sformatf("vec%0d", i), vectors[i].valid, vectors[i].d0, vectors[i].d1,
                vectors[i].fgi, vectors[i].exp);

    $display("[TB] fgi held high with a request pending");
    for (int k = 0; k < 3; k++)
      stepCheck($sformatf("t3_hold%0d", k), 2'b01, 8'h55, 8'h00, 1'b1,
                mko(1'b0, 2'b00, 8'h41, 1'b0, 1'b0, 1'b0));
    stepCheck("t3_fall", 2'b01, 8'h55, 8'h00, 1'b0, mko(1'b1, 2'b01, 8'h55, 1'b0, 1'b1, 1'b0));
    finishHandshake("t3", 8'h55, 1'b0);

    $display("[TB] fgi stuck low after a load");
    stepCheck("t4_load", 2'b10, 8'h00, 8'h66, 1'b0, mko(1'b1, 2'b10, 8'h66, 1'b1, 1'b1, 1'b0));
    for (int s = 1; s <= 20; s++)
      stepCheck($sformatf("t4_step%0d", s), 2'b00, 8'h00, 8'h00, 1'b0,
                mko(1'b0, 2'b00, 8'h66, 1'b1, (s < 16), (s == 16)));
    stepCheck("t4_next", 2'b01, 8'h77, 8'h00, 1'b0, mko(1'b1, 2'b01, 8'h77, 1'b0, 1'b1, 1'b0));
    finishHandshake("t4n", 8'h77, 1'b0);

    $display("[TB] reset asserted during LOAD");
    stepCheck("t5_load", 2'b10, 8'h00, 8'h88, 1'b0, mko(1'b1, 2'b10, 8'h88, 1'b1, 1'b1, 1'b0));
    #1;
    reset_n_in       = 1'b0;
    bus.req_valid_in = 2'b00;
    #1;
    checkOutput("t5_async_reset", mko(1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0));
    @(negedge clock);
    reset_n_in = 1'b1;
    stepCheck("t5_grant", 2'b11, 8'hA0, 8'hA1, 1'b0, mko(1'b1, 2'b01, 8'hA0, 1'b0, 1'b1, 1'b0));
    finishHandshake("t5", 8'hA0, 1'b0);

    $display("[TB] request withdrawn while fgi is high");
    for (int k = 0; k < 2; k++)
      stepCheck($sformatf("t6_hold%0d", k), 2'b10, 8'h00, 8'hB1, 1'b1,
                mko(1'b0, 2'b00, 8'hA0, 1'b0, 1'b0, 1'b0));
    stepCheck("t6_withdraw", 2'b00, 8'h00, 8'hB1, 1'b1, mko(1'b0, 2'b00, 8'hA0, 1'b0, 1'b0, 1'b0));
    for (int k = 0; k < 2; k++)
      stepCheck($sformatf("t6_low%0d", k), 2'b00, 8'h00, 8'hB1, 1'b0,
                mko(1'b0, 2'b00, 8'hA0, 1'b0, 1'b0, 1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
